// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter: operation encoding and the
// helper that derives the number of shift levels from the data width.
package shifter_pkg;

    typedef enum logic [2:0] {
        SLL = 3'd0,
        SRL = 3'd1,
        SRA = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4
    } shift_op_t;

    function automatic int levelCount(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational level of the barrel shifter: shifts or rotates by 2^K
// when the level's shift-amount bit is set.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int N = 32,
    parameter int K = 0
) (
    input  logic [N-1:0] data_i,
    input  logic         shift_i,
    input  shift_op_t    op_i,
    input  logic         sign_i,
    output logic [N-1:0] data_o
);

    localparam int AMT = 1 << K;

    logic [N-1:0] shifted;
    logic [N-1:0] signFill;

    // Sign fill covers exactly the AMT vacated top bits of an arithmetic shift.
    always_comb begin
        signFill = sign_i ? ~({N{1'b1}} >> AMT) : '0;
        shifted  = data_i;
        case (op_i)
            SLL:     shifted = data_i << AMT;
            SRL:     shifted = data_i >> AMT;
            SRA:     shifted = (data_i >> AMT) | signFill;
            ROL:     shifted = (data_i << AMT) | (data_i >> (N - AMT));
            ROR:     shifted = (data_i >> AMT) | (data_i << (N - AMT));
            default: shifted = data_i;
        endcase
        data_o = shift_i ? shifted : data_i;
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Barrel shifter split into S registered levels with a valid/ready handshake;
// a single advance signal stalls every stage together under backpressure.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter  int N = 32,
    localparam int S = levelCount(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [S-1:0] in_shamt,
    input  shift_op_t    in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    logic         advance;
    logic [S-1:0] stageValid_q;
    logic [N-1:0] stageData_q  [S];
    logic [N-1:0] stageData_d  [S];
    logic [S-1:0] stageShamt_q [S];
    shift_op_t    stageOp_q    [S];
    logic         stageSign_q  [S];

    assign advance   = !stageValid_q[S-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = stageValid_q[S-1];
    assign out_data  = stageData_q[S-1];

    for (genvar k = 0; k < S; k++) begin : gLevel
        if (k == 0) begin : gFirst
            shift_stage #(.N(N), .K(0)) uStage (
                .data_i  (in_data),
                .shift_i (in_shamt[0]),
                .op_i    (in_op),
                .sign_i  (in_data[N-1]),
                .data_o  (stageData_d[0])
            );
        end else begin : gNext
            shift_stage #(.N(N), .K(k)) uStage (
                .data_i  (stageData_q[k-1]),
                .shift_i (stageShamt_q[k-1][k]),
                .op_i    (stageOp_q[k-1]),
                .sign_i  (stageSign_q[k-1]),
                .data_o  (stageData_d[k])
            );
        end
    end

    // The sign bit is captured once at entry so SRA fills from the original MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stageValid_q <= '0;
            for (int k = 0; k < S; k++) begin
                stageData_q[k]  <= '0;
                stageShamt_q[k] <= '0;
                stageOp_q[k]    <= SLL;
                stageSign_q[k]  <= 1'b0;
            end
        end else if (advance) begin
            stageValid_q    <= {stageValid_q[S-2:0], in_valid};
            stageData_q[0]  <= stageData_d[0];
            stageShamt_q[0] <= in_shamt;
            stageOp_q[0]    <= in_op;
            stageSign_q[0]  <= in_data[N-1];
            for (int k = 1; k < S; k++) begin
                stageData_q[k]  <= stageData_d[k];
                stageShamt_q[k] <= stageShamt_q[k-1];
                stageOp_q[k]    <= stageOp_q[k-1];
                stageSign_q[k]  <= stageSign_q[k-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed and randomised checks of pipelined_shifter at N=32, plus a
// random stream against an N=8 instance.
module tb_pipelined_shifter;
    import shifter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    shift_op_t   in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    logic        bInValid;
    logic        bInReady;
    logic [7:0]  bInData;
    logic [2:0]  bInShamt;
    shift_op_t   bInOp;
    logic        bOutValid;
    logic        bOutReady;
    logic [7:0]  bOutData;

    int vecCount = 0;
    int errCount = 0;

    typedef struct {
        shift_op_t   op;
        logic [31:0] d;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    pipelined_shifter #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    pipelined_shifter #(.N(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bInValid),
        .in_ready  (bInReady),
        .in_data   (bInData),
        .in_shamt  (bInShamt),
        .in_op     (bInOp),
        .out_valid (bOutValid),
        .out_ready (bOutReady),
        .out_data  (bOutData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural reference written as whole-word shifts, independent of the level structure.
    function automatic logic [63:0] model(input int n, input logic [63:0] din,
                                          input int sh, input logic [2:0] op);
        logic [63:0] mask;
        logic [63:0] d;
        logic [63:0] r;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        d    = din & mask;
        case (op)
            3'd0:    r = (d << sh) & mask;
            3'd1:    r = d >> sh;
            3'd2: begin
                r = d >> sh;
                if (d[n-1]) r = r | (mask & ~(mask >> sh));
            end
            3'd3:    r = ((d << sh) | (d >> (n - sh))) & mask;
            3'd4:    r = ((d >> sh) | (d << (n - sh))) & mask;
            default: r = d;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        in_shamt = 5'd3;
        in_op    = SLL;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vecCount++;
        if (out_valid !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        vecCount++;
        if (out_data !== 32'h0) begin
            errCount++;
            $display("[TB] FAIL reset_out_data: got %h expected 00000000", out_data);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        vecCount++;
        if (in_ready !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_latency();
        logic [31:0] dIn  [2];
        logic [31:0] dExp [2];
        int lat;
        dIn[0] = 32'h0888_8888; dExp[0] = 32'h0000_0000;
        dIn[1] = 32'h0000_0001; dExp[1] = 32'h8000_0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_op     = SLL;
            in_data   = dIn[i];
            in_shamt  = 5'd31;
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            #1;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                #1;
                lat++;
            end
            vecCount++;
            if (lat !== 5) begin
                errCount++;
                $display("[TB] FAIL latency[%0d]: got %0d cycles expected 5", i, lat);
            end
            vecCount++;
            if (out_data !== dExp[i]) begin
                errCount++;
                $display("[TB] FAIL latency_data[%0d]: got %h expected %h", i, out_data, dExp[i]);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_ops();
        vec_t vecs[$];
        logic [31:0] expQ[$];
        logic [31:0] e;
        int idx, got, cycles;
        vecs.push_back('{SRA, 32'h8000_0000, 5'd4,  32'hF800_0000});
        vecs.push_back('{SRL, 32'h8000_0000, 5'd4,  32'h0800_0000});
        vecs.push_back('{ROL, 32'h8000_0001, 5'd1,  32'h0000_0003});
        vecs.push_back('{ROR, 32'h0000_0001, 5'd1,  32'h8000_0000});
        vecs.push_back('{SLL, 32'h1234_5678, 5'd0,  32'h1234_5678});
        vecs.push_back('{SRA, 32'h8765_4321, 5'd0,  32'h8765_4321});
        vecs.push_back('{ROR, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF});
        vecs.push_back('{SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF});
        vecs.push_back('{SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000});
        vecs.push_back('{SRL, 32'hF000_0000, 5'd31, 32'h0000_0001});
        vecs.push_back('{ROL, 32'h1234_5678, 5'd8,  32'h3456_7812});
        vecs.push_back('{ROR, 32'h1234_5678, 5'd4,  32'h8123_4567});
        vecs.push_back('{shift_op_t'(3'd5), 32'hCAFE_F00D, 5'd7, 32'hCAFE_F00D});
        vecs.push_back('{shift_op_t'(3'd7), 32'h1357_9BDF, 5'd3, 32'h1357_9BDF});
        idx = 0; got = 0; cycles = 0;
        while (got < vecs.size() && cycles < 100) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (idx < vecs.size()) begin
                in_valid = 1'b1;
                in_op    = vecs[idx].op;
                in_data  = vecs[idx].d;
                in_shamt = vecs[idx].sh;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                vecCount++;
                if (expQ.size() == 0) begin
                    errCount++;
                    $display("[TB] FAIL ops_spurious: got %h expected no output", out_data);
                end else begin
                    e = expQ.pop_front();
                    if (out_data !== e) begin
                        errCount++;
                        $display("[TB] FAIL ops[%0d]: got %h expected %h", got, out_data, e);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                expQ.push_back(vecs[idx].exp);
                idx++;
            end
            cycles++;
        end
        in_valid = 1'b0;
        if (got < vecs.size()) begin
            vecCount++;
            errCount++;
            $display("[TB] FAIL ops_timeout: got %0d results expected %0d", got, vecs.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expQ[$];
        logic [31:0] e;
        logic [31:0] heldData;
        logic        wasStalled;
        int idx, got, c;
        idx = 0; got = 0; c = 0; wasStalled = 1'b0; heldData = '0;
        while (got < 8 && c < 60) begin
            @(negedge clk);
            out_ready = !(c >= 7 && c < 10);
            if (idx < 8) begin
                in_valid = 1'b1;
                in_data  = (idx % 2 == 0) ? 32'h0000_0003 : 32'h0000_0001;
                in_op    = (idx % 2 == 0) ? SLL : ROR;
                in_shamt = 5'(idx);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (wasStalled) begin
                vecCount++;
                if (out_data !== heldData) begin
                    errCount++;
                    $display("[TB] FAIL stall_hold: got %h expected %h", out_data, heldData);
                end
            end
            if (!out_ready && out_valid) begin
                vecCount++;
                if (in_ready !== 1'b0) begin
                    errCount++;
                    $display("[TB] FAIL stall_in_ready: got %b expected 0", in_ready);
                end
            end
            wasStalled = out_valid && !out_ready;
            heldData   = out_data;
            if (out_valid && out_ready) begin
                vecCount++;
                e = (expQ.size() != 0) ? expQ.pop_front() : 32'hXXXX_XXXX;
                if (out_data !== e) begin
                    errCount++;
                    $display("[TB] FAIL b2b[%0d]: got %h expected %h", got, out_data, e);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                expQ.push_back((idx % 2 == 0) ? (32'h3 << idx) : (32'h1 << (32 - idx)));
                idx++;
            end
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (got < 8) begin
            vecCount++;
            errCount++;
            $display("[TB] FAIL b2b_timeout: got %0d results expected 8", got);
        end
    endtask

    task automatic test_reset_midflight();
        logic sawStale;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_op     = SLL;
            in_data   = 32'h0000_0001;
            in_shamt  = 5'(c);
        end
        #1;
        vecCount++;
        if (out_valid !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL midflight_pre: got out_valid %b expected 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vecCount++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            errCount++;
            $display("[TB] FAIL midflight_async: got valid %b data %h expected 0 00000000",
                     out_valid, out_data);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sawStale = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) sawStale = 1'b1;
        end
        vecCount++;
        if (sawStale !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL midflight_stale: got stale output 1 expected 0");
        end
    endtask

    task automatic test_random();
        localparam int NV = 10000;
        logic [63:0] qA[$];
        logic [63:0] qB[$];
        logic [63:0] e;
        int sentA, gotA, sentB, gotB, cycles;
        sentA = 0; gotA = 0; sentB = 0; gotB = 0; cycles = 0;
        while ((gotA < NV || gotB < NV) && cycles < 40000) begin
            @(negedge clk);
            out_ready = ($urandom_range(3) != 0);
            bOutReady = ($urandom_range(3) != 0);
            in_valid  = (sentA < NV) && ($urandom_range(3) != 0);
            in_data   = $urandom;
            in_shamt  = 5'($urandom_range(31));
            in_op     = shift_op_t'(3'($urandom_range(7)));
            bInValid  = (sentB < NV) && ($urandom_range(3) != 0);
            bInData   = 8'($urandom);
            bInShamt  = 3'($urandom_range(7));
            bInOp     = shift_op_t'(3'($urandom_range(7)));
            #1;
            if (out_valid && out_ready) begin
                vecCount++;
                e = (qA.size() != 0) ? qA.pop_front() : 64'hXXXX_XXXX_XXXX_XXXX;
                if (out_data !== e[31:0]) begin
                    errCount++;
                    $display("[TB] FAIL rand32[%0d]: got %h expected %h", gotA, out_data, e[31:0]);
                end
                gotA++;
            end
            if (in_valid && in_ready) begin
                qA.push_back(model(32, {32'h0, in_data}, int'(in_shamt), in_op));
                sentA++;
            end
            if (bOutValid && bOutReady) begin
                vecCount++;
                e = (qB.size() != 0) ? qB.pop_front() : 64'hXXXX_XXXX_XXXX_XXXX;
                if (bOutData !== e[7:0]) begin
                    errCount++;
                    $display("[TB] FAIL rand8[%0d]: got %h expected %h", gotB, bOutData, e[7:0]);
                end
                gotB++;
            end
            if (bInValid && bInReady) begin
                qB.push_back(model(8, {56'h0, bInData}, int'(bInShamt), bInOp));
                sentB++;
            end
            cycles++;
        end
        in_valid = 1'b0;
        bInValid = 1'b0;
        if (gotA < NV || gotB < NV) begin
            vecCount++;
            errCount++;
            $display("[TB] FAIL rand_timeout: got %0d/%0d results expected %0d each", gotA, gotB, NV);
        end
    endtask

    initial begin
        bInValid  = 1'b0;
        bInData   = '0;
        bInShamt  = '0;
        bInOp     = SLL;
        bOutReady = 1'b1;
        test_reset();
        test_latency();
        test_ops();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
